inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth in entries (power of 2, at least 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  encode request present.
REQ-005 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_sel  input  4  operation code: 0 add, 1 addi, 2 sub, 3 and, 4 lw, 5 sw, 6 lhu, 7 lh, 8 sll, 9 srl, 10 or, 11 slt, 12 sltu; 13-15 illegal.
REQ-007 SHALL have ports req_rs, req_rt, req_rd, req_shamt  input  5 each  register and shift fields.
REQ-008 SHALL have port req_imm  input  16  immediate for I-type.
REQ-009 SHALL have port inst  output  32  encoded instruction word at FIFO head.
REQ-010 SHALL have port inst_valid  output  1  inst holds a valid word.
REQ-011 SHALL have port inst_ready  input  1  consumer takes word when high with inst_valid.
REQ-012 SHALL have port err  output  1  one-cycle pulse on acceptance of an illegal req_sel.
REQ-013 SHALL have port err_cnt  output  8  saturating count of illegal requests.

Function
REQ-014 R-type (add, sub, and, or, slt, sltu) SHALL encode {6'b000000, rs, rt, rd, 5'b00000, func}, with func 100000, 100010, 100100, 100101, 101010, 101011; req_shamt ignored.
REQ-015 sll/srl SHALL encode {6'b000000, 5'b00000, rt, rd, shamt, func}, with func 000000 and 000010; req_rs ignored.
REQ-016 I-type SHALL encode {op, rs, rt, imm}, with op addi 001000, lw 100011, sw 101011, lhu 100101, lh 100001; req_rd and req_shamt ignored.
REQ-017 req_ready SHALL equal (count != DEPTH), registered state only, with no combinational path from inst_ready.
REQ-018 A legal accepted request SHALL push one encoded word; inst_valid SHALL rise the following cycle when the FIFO was empty (latency 1).
REQ-019 inst_valid SHALL equal (count != 0); inst SHALL show the head entry, and 32'h0 when empty.
REQ-020 A pop (inst_valid and inst_ready) SHALL advance the read pointer; head order SHALL be strict FIFO.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and be legal when full (pop frees, push fills) only if req_ready was high; at full, req_ready low blocks the push regardless of pop.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 An illegal req_sel accepted (req_valid and req_ready) SHALL push nothing, pulse err for exactly the next cycle, and increment err_cnt, saturating at 255.
REQ-024 Requests with req_valid low SHALL have no effect; inputs SHALL be sampled only at acceptance.
REQ-025 The block SHALL hold no state other than the FIFO storage, pointers, count, err, and err_cnt.

Reset
REQ-026 rst high SHALL immediately clear the pointers, count, err, and err_cnt, forcing inst_valid=0, inst=0, and req_ready=1.
REQ-027 Reset asserted mid-stream SHALL discard all buffered words; no partial word SHALL appear after release.
REQ-028 The first acceptance SHALL occur on the first rising edge with rst low.

Verification
REQ-029 add with rs=1, rt=2, rd=3 and inst_ready=1 -> next cycle inst=32'h00221820 with inst_valid=1.
REQ-030 lw with rs=29, rt=8, imm=16'h0004 -> inst=32'h8FA80004; sll with rt=9, rd=10, shamt=2 -> inst=32'h00095080.
REQ-031 Push 5 requests with inst_ready=0 and DEPTH=4 -> req_ready drops after 4 acceptances; then raise inst_ready -> the 4 words emerge in order, then the 5th.
REQ-032 Full FIFO with inst_ready=1 and req_valid=1 -> req_ready=0 that cycle, count 4 then 3, and the next request is accepted.
REQ-033 req_sel=14 accepted -> no inst_valid, err pulses for 1 cycle, err_cnt=1; 300 illegal requests -> err_cnt=255.
REQ-034 rst pulsed with 3 words buffered -> inst_valid=0 and err_cnt=0 immediately; no stale word after release.

Source files
------------

// File: rtl/inst_encoder.sv
// MIPS-style instruction encoder feeding a DEPTH-entry output FIFO; a word appears one cycle after acceptance.
// req_ready tracks FIFO occupancy only (no path from inst_ready); illegal opcodes push nothing and raise err.

module enc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign head_dat = mem[rptr];

  // Pointers are exactly log2(DEPTH) bits, so wrap is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end
endmodule

module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_sel,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        err,
  output logic [7:0]  err_cnt
);
  logic        legal;
  logic [31:0] word;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    case (req_sel)
      4'd0:  word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      4'd1:  word = {6'b001000, req_rs, req_rt, req_imm};
      4'd2:  word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
      4'd3:  word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100};
      4'd4:  word = {6'b100011, req_rs, req_rt, req_imm};
      4'd5:  word = {6'b101011, req_rs, req_rt, req_imm};
      4'd6:  word = {6'b100101, req_rs, req_rt, req_imm};
      4'd7:  word = {6'b100001, req_rs, req_rt, req_imm};
      4'd8:  word = {6'b000000, 5'b00000, req_rt, req_rd, req_shamt, 6'b000000};
      4'd9:  word = {6'b000000, 5'b00000, req_rt, req_rd, req_shamt, 6'b000010};
      4'd10: word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100101};
      4'd11: word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b101010};
      4'd12: word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b101011};
      default: legal = 1'b0;
    endcase
  end

  assign accept     = req_valid & req_ready;
  assign push       = accept & legal;
  assign pop        = inst_valid & inst_ready;
  assign req_ready  = ~full;
  assign inst_valid = ~empty;
  assign inst       = empty ? 32'h0 : head;

  enc_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (word),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_dat (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= 8'h00;
    end else begin
      err <= accept & ~legal;
      if (accept && !legal && err_cnt != 8'hff) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule
